// File: rtl/spi_lcd_pkg.sv
// Shared types for the LCD-side SPI receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_lcd_pkg;

    localparam int LCD_BYTE_W = 8;

    // One received byte tagged with its D/C flag (0 = command, 1 = data).
    typedef struct packed {
        logic                  dc;
        logic [LCD_BYTE_W-1:0] data;
    } lcd_word_t;

    // IDLE while chip select is high, SHIFT while a frame is open.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/lcd_word_fifo.sv
// Synchronous FIFO of tagged LCD words.
// Latency: written word visible at head one cycle after push.
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
// Ports: clk, reset_n, push/push_data/full (write side), pop/empty/head (read side).
module lcd_word_fifo
    import spi_lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  lcd_word_t push_data,
    output logic      full,
    input  logic      pop,
    output logic      empty,
    output lcd_word_t head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    lcd_word_t   mem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A push while full and popping overwrites the slot being vacated;
    // the head read this cycle still sees the old contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level into clk.
// Latency: STAGES clk cycles.
// Backpressure: none; samples every cycle.
// Ports: clk, reset_n (async active-low), d (async input), q (synchronised).
module sync_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_lcd_rx.sv
// SPI mode-0 target for the LCD link: deserialises bytes into D/C-tagged words.
// Latency: 8th spi_clk rise at the pin to out_valid is SYNC_STAGES + 2 clk cycles.
// Backpressure: out_valid/out_ready; a completed byte arriving with the FIFO full is dropped (overflow pulse).
// Ports: clk, reset_n; SPI pins spi_clk/spi_mosi/spi_cs_n/lcd_dc;
//        out_valid/out_ready/out_data/out_dc word stream; busy, overflow, frame_err status.
module spi_lcd_rx
    import spi_lcd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    input  logic                  lcd_dc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LCD_BYTE_W-1:0] out_data,
    output logic                  out_dc,
    output logic                  busy,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int BIT_CNT_W = $clog2(LCD_BYTE_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(LCD_BYTE_W - 1);

    // ---------------------------------------------------------------- sync
    logic spi_clk_s, mosi_s, cs_n_s, dc_s;
    logic sync_ok;

    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk(clk), .reset_n(reset_n), .d(spi_clk), .q(spi_clk_s)
    );
    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(spi_mosi), .q(mosi_s)
    );
    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .d(spi_cs_n), .q(cs_n_s)
    );
    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc (
        .clk(clk), .reset_n(reset_n), .d(lcd_dc), .q(dc_s)
    );

    // Goes high once the cs chain has flushed its reset value, i.e. when
    // cs_n_s first reflects the real pin after reset release.
    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ok (
        .clk(clk), .reset_n(reset_n), .d(1'b1), .q(sync_ok)
    );

    // -------------------------------------------------------- edge detect
    logic spi_clk_d, cs_n_d;
    logic spi_rise, cs_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_clk_d <= 1'b0;
            cs_n_d    <= 1'b1;
        end else begin
            spi_clk_d <= spi_clk_s;
            cs_n_d    <= cs_n_s;
        end
    end

    assign spi_rise = spi_clk_s & ~spi_clk_d;
    assign cs_rise  = cs_n_s & ~cs_n_d;

    // ------------------------------------------------------ shift engine
    rx_state_t               state;
    logic                    armed;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [LCD_BYTE_W-1:0]   shreg;
    logic                    word_dc;
    logic                    word_vld;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            word_dc   <= 1'b0;
            word_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            word_vld  <= 1'b0;
            frame_err <= 1'b0;

            // A frame may only open after cs has been seen high post-reset,
            // so a reset in mid-frame never locks onto a partial stream.
            if (sync_ok && cs_n_s) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (armed && !cs_n_s) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_n_s) begin
                        state <= IDLE;
                    end else if (spi_rise) begin
                        shreg   <= {shreg[LCD_BYTE_W-2:0], mosi_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            // shreg holds the full byte next cycle, when it is pushed.
                            word_dc  <= dc_s;
                            word_vld <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (cs_rise && (bit_cnt != '0)) begin
                bit_cnt   <= '0;
                shreg     <= '0;
                frame_err <= 1'b1;
            end
        end
    end

    // --------------------------------------------------------------- FIFO
    logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
    lcd_word_t fifo_head;
    lcd_word_t push_word;

    assign push_word = '{dc: word_dc, data: shreg};
    assign fifo_pop  = out_valid & out_ready;
    // Full is judged after a same-cycle pop, so push+pop while full succeeds.
    assign fifo_push = word_vld & (~fifo_full | fifo_pop);

    lcd_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_word),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= word_vld & fifo_full & ~fifo_pop;
        end
    end

    // -------------------------------------------------------------- outputs
    assign out_valid = ~fifo_empty;
    // Masked when empty so the unreset storage never shows on the outputs.
    assign out_data  = fifo_empty ? '0   : fifo_head.data;
    assign out_dc    = fifo_empty ? 1'b0 : fifo_head.dc;
    assign busy      = (state == SHIFT) || (bit_cnt != '0);

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed bench for spi_lcd_rx: drives SPI frames at clk/8 and checks the word stream.
// Latency: n/a.
// Backpressure: exercised through out_ready.
module tb_spi_lcd_rx;

    localparam int SS = 2;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       spi_clk   = 1'b0;
    logic       spi_mosi  = 1'b0;
    logic       spi_cs_n  = 1'b1;
    logic       lcd_dc    = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_dc;
    logic       busy;
    logic       overflow;
    logic       frame_err;

    always #5 clk = ~clk;

    spi_lcd_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .lcd_dc    (lcd_dc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dc    (out_dc),
        .busy      (busy),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ovf_cnt  = 0;
    int         ferr_cnt = 0;
    logic [8:0] got[$];
    int         rd = 0;

    // Observe away from the active edge; inputs only change 1ns after posedge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (overflow)  ovf_cnt  = ovf_cnt + 1;
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (out_valid && out_ready) got.push_back({out_dc, out_data});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_rise(input logic b, input logic dc);
        spi_mosi = b;
        lcd_dc   = dc;
        tick(4);
        spi_clk  = 1'b1;
    endtask

    task automatic bit_fall();
        tick(4);
        spi_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            bit_rise(b[i], dc);
            bit_fall();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8);
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_end();
        spi_cs_n = 1'b1;
        tick(6);
    endtask

    task automatic expect_word(input string tag, input logic [8:0] exp);
        logic [31:0] w;
        if (rd < got.size()) w = {23'd0, got[rd]};
        else                 w = 32'hDEAD;
        rd++;
        check_eq(tag, w, {23'd0, exp});
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        tick(n);
        out_ready = 1'b0;
    endtask

    int ovf0, ferr0;

    initial begin
        // ---------------- reset state
        tick(3);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data",  {24'd0, out_data},  32'd0);
        check_eq("rst_out_dc",    {31'd0, out_dc},    32'd0);
        check_eq("rst_busy",      {31'd0, busy},      32'd0);
        check_eq("rst_overflow",  {31'd0, overflow},  32'd0);
        check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset_n = 1'b1;
        tick(5);

        // ---------------- single byte 0xA5, latency
        ovf0 = ovf_cnt; ferr0 = ferr_cnt;
        cs_begin();
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        send_bits(8'hA5, 1'b0, 7);
        bit_rise(1'b1, 1'b0);
        tick(SS + 1);
        check_eq("t1_valid_early", {31'd0, out_valid}, 32'd0);
        tick(1);
        check_eq("t1_valid_lat", {31'd0, out_valid}, 32'd1);
        check_eq("t1_data", {24'd0, out_data}, 32'hA5);
        check_eq("t1_dc",   {31'd0, out_dc},   32'd0);
        bit_fall();
        check_eq("t1_data_hold", {24'd0, out_data}, 32'hA5);
        drain(1);
        expect_word("t1_pop", {1'b0, 8'hA5});
        check_eq("t1_empty", {31'd0, out_valid}, 32'd0);
        cs_end();
        check_eq("t1_ovf",  ovf_cnt - ovf0,   32'd0);
        check_eq("t1_ferr", ferr_cnt - ferr0, 32'd0);

        // ---------------- three bytes in one frame, ready high
        out_ready = 1'b1;
        cs_begin();
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h7F, 1'b1);
        tick(6);
        out_ready = 1'b0;
        cs_end();
        expect_word("t2_w0", {1'b0, 8'h2A});
        expect_word("t2_w1", {1'b1, 8'h00});
        expect_word("t2_w2", {1'b1, 8'h7F});
        check_eq("t2_pops", got.size(), rd);
        check_eq("t2_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- overflow on 5th byte
        ovf0 = ovf_cnt; ferr0 = ferr_cnt;
        cs_begin();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b1);
        tick(6);
        cs_end();
        check_eq("t3_ovf", ovf_cnt - ovf0, 32'd1);
        check_eq("t3_head", {23'd0, out_dc, out_data}, {23'd0, 1'b1, 8'h11});
        drain(8);
        expect_word("t3_w0", {1'b1, 8'h11});
        expect_word("t3_w1", {1'b0, 8'h22});
        expect_word("t3_w2", {1'b1, 8'h33});
        expect_word("t3_w3", {1'b0, 8'h44});
        check_eq("t3_pops", got.size(), rd);
        check_eq("t3_ferr", ferr_cnt - ferr0, 32'd0);

        // ---------------- truncated byte then recovery
        ferr0 = ferr_cnt;
        cs_begin();
        send_bits(8'hA0, 1'b0, 3);
        cs_end();
        check_eq("t4_ferr", ferr_cnt - ferr0, 32'd1);
        check_eq("t4_nopush", {31'd0, out_valid}, 32'd0);
        check_eq("t4_busy", {31'd0, busy}, 32'd0);
        out_ready = 1'b1;
        cs_begin();
        send_byte(8'h3C, 1'b1);
        tick(6);
        out_ready = 1'b0;
        cs_end();
        expect_word("t4_w0", {1'b1, 8'h3C});
        check_eq("t4_pops", got.size(), rd);
        check_eq("t4_ferr_once", ferr_cnt - ferr0, 32'd1);

        // ---------------- reset mid-byte, re-arm only after cs high
        ferr0 = ferr_cnt;
        cs_begin();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        send_bits(8'hF0, 1'b0, 4);
        check_eq("t5_queued", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("t5_async_valid", {31'd0, out_valid}, 32'd0);
        check_eq("t5_async_busy",  {31'd0, busy},      32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(5);
        send_byte(8'hFF, 1'b1);
        tick(6);
        check_eq("t5_no_resync", {31'd0, out_valid}, 32'd0);
        cs_end();
        out_ready = 1'b1;
        cs_begin();
        send_byte(8'h81, 1'b0);
        tick(6);
        out_ready = 1'b0;
        cs_end();
        expect_word("t5_w0", {1'b0, 8'h81});
        check_eq("t5_pops", got.size(), rd);
        check_eq("t5_ferr", ferr_cnt - ferr0, 32'd0);

        // ---------------- push and pop in the same cycle while full
        ovf0 = ovf_cnt;
        cs_begin();
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0);
        send_bits(8'hA5, 1'b1, 7);
        bit_rise(1'b1, 1'b1);
        tick(SS + 1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        bit_fall();
        check_eq("t6_ovf", ovf_cnt - ovf0, 32'd0);
        check_eq("t6_head", {24'd0, out_data}, 32'hA2);
        expect_word("t6_pop", {1'b0, 8'hA1});
        drain(8);
        cs_end();
        expect_word("t6_w1", {1'b0, 8'hA2});
        expect_word("t6_w2", {1'b0, 8'hA3});
        expect_word("t6_w3", {1'b0, 8'hA4});
        expect_word("t6_w4", {1'b1, 8'hA5});
        check_eq("t6_pops", got.size(), rd);
        check_eq("t6_empty", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
